// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline front end.
package pipeline_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: flush inserts a bubble and overrides load; otherwise holds.
module if_id_pipe_reg
  import pipeline_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [WORD_W-1:0] next_pc_plus4,
  input  logic [WORD_W-1:0] next_instr,
  output logic [WORD_W-1:0] pc_plus4,
  output logic [WORD_W-1:0] instr,
  output logic              valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_plus4 <= '0;
      instr    <= NOP;
      valid    <= 1'b0;
    end else if (flush) begin
      pc_plus4 <= '0;
      instr    <= NOP;
      valid    <= 1'b0;
    end else if (load) begin
      pc_plus4 <= next_pc_plus4;
      instr    <= next_instr;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC, single-outstanding imem request, skid buffer for stalled returns,
// and DROP state that waits out a request squashed by a branch.
module instruction_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PC_Write,
  input  logic              IF_ID_write,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] IF_ID_pc_plus4,
  output logic [WORD_W-1:0] IF_ID_instr,
  output logic              IF_ID_valid
);

  fetch_state_t      state;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] drop_addr;
  logic [WORD_W-1:0] skid;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] load_instr;
  logic              stall;
  logic              load;
  logic              flush;

  assign stall    = !PC_Write || !IF_ID_write;
  assign pc_plus4 = word_align(pc + 32'd4);

  always_comb begin
    load       = 1'b0;
    load_instr = imem_rdata;
    case (state)
      FETCH:   load = imem_rvalid && !stall;
      HOLD: begin
        load       = !stall;
        load_instr = skid;
      end
      default: load = 1'b0;
    endcase
    if (branch_taken) load = 1'b0;
  end

  // A redirect always bubbles IF/ID; otherwise bubble only if IF/ID is allowed to move.
  assign flush = branch_taken || (!load && IF_ID_write);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= word_align(RESET_PC);
      drop_addr <= '0;
      skid      <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          if (branch_taken) pc <= word_align(branch_target);
        end
        FETCH: begin
          if (branch_taken) begin
            pc <= word_align(branch_target);
            if (!imem_rvalid) begin
              drop_addr <= pc;
              state     <= DROP;
            end
          end else if (imem_rvalid) begin
            if (!stall) begin
              pc <= pc_plus4;
            end else begin
              skid  <= imem_rdata;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (branch_taken) begin
            pc    <= word_align(branch_target);
            state <= FETCH;
          end else if (!stall) begin
            pc    <= pc_plus4;
            state <= FETCH;
          end
        end
        DROP: begin
          if (branch_taken) pc <= word_align(branch_target);
          if (imem_rvalid) state <= FETCH;
        end
        default: state <= BOOT;
      endcase
    end
  end

  // DROP keeps presenting the squashed address until its response is consumed.
  assign imem_req  = (state == FETCH) || (state == DROP);
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  if_id_pipe_reg u_if_id (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (load),
    .flush         (flush),
    .next_pc_plus4 (pc_plus4),
    .next_instr    (load_instr),
    .pc_plus4      (IF_ID_pc_plus4),
    .instr         (IF_ID_instr),
    .valid         (IF_ID_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomized bench for instruction_fetch_stage against a transaction-level fetch model.
module tb_instruction_fetch_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PC_Write = 1'b1;
  logic        IF_ID_write = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_pc_plus4;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;

  int mem_cnt = 0;
  int mem_lat = 0;
  int mem_max = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Model: next instruction address owed to ID, whether a fetched word is parked,
  // and whether the outstanding memory request was squashed by a branch.
  logic [31:0] exp_pc;
  bit          avail;
  bit          dead;
  logic [31:0] dead_addr;
  bit          booted;
  logic [31:0] m_pc4;
  logic [31:0] m_instr;
  logic        m_valid;

  always #5 clk = ~clk;

  // Memory with per-request random latency; the word returned is addr + 0x100.
  assign imem_rvalid = imem_req && (mem_cnt >= mem_lat);
  assign imem_rdata  = imem_addr + 32'h100;

  instruction_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PC_Write       (PC_Write),
    .IF_ID_write    (IF_ID_write),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .IF_ID_pc_plus4 (IF_ID_pc_plus4),
    .IF_ID_instr    (IF_ID_instr),
    .IF_ID_valid    (IF_ID_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc    = 32'h0;
    avail     = 0;
    dead      = 0;
    dead_addr = 32'h0;
    booted    = 0;
    m_pc4     = 32'h0;
    m_instr   = 32'h0;
    m_valid   = 1'b0;
    mem_cnt   = 0;
    mem_lat   = $urandom_range(0, mem_max);
  endtask

  task automatic check_reset_outputs();
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_pc_plus4", IF_ID_pc_plus4, 32'h0);
    check("rst_instr", IF_ID_instr, 32'h0);
    check("rst_valid", 32'(IF_ID_valid), 32'h0);
  endtask

  // Called at a negedge; drives one cycle of stimulus, predicts, checks, returns at next negedge.
  task automatic step();
    logic        s_req, s_rv, s_pcw, s_ifw, s_br;
    logic [31:0] s_addr, s_bt;
    bit          stall, resp_live, have;
    PC_Write     = ($urandom_range(0, 3) != 0);
    IF_ID_write  = ($urandom_range(0, 3) != 0);
    branch_taken = ($urandom_range(0, 9) == 0);
    if ($urandom_range(0, 7) == 0) branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    else branch_target = 32'($urandom_range(0, 255));
    #1;
    s_req = imem_req;  s_addr = imem_addr;  s_rv = imem_rvalid;
    s_pcw = PC_Write;  s_ifw = IF_ID_write; s_br = branch_taken; s_bt = branch_target;

    check("imem_req", 32'(s_req), 32'(booted && !avail));
    if (s_req) check("imem_addr", s_addr, dead ? dead_addr : exp_pc);

    stall     = !s_pcw || !s_ifw;
    resp_live = s_req && s_rv && !dead;
    have      = avail || resp_live;
    if (s_br) begin
      m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      avail = 0;
      if (s_req && !s_rv) begin
        if (!dead) dead_addr = s_addr;
        dead = 1;
      end else if (s_req && s_rv) begin
        dead = 0;
      end
      exp_pc = s_bt & ~32'h3;
    end else begin
      if (s_req && s_rv && dead) dead = 0;
      if (have && !stall) begin
        m_pc4   = exp_pc + 32'd4;
        m_instr = exp_pc + 32'h100;
        m_valid = 1'b1;
        avail   = 0;
        exp_pc  = exp_pc + 32'd4;
      end else begin
        if (have) avail = 1;
        if (s_ifw) begin
          m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        end
      end
    end
    booted = 1;

    @(posedge clk);
    #1;
    if (s_req && s_rv) begin
      mem_cnt = 0;
      mem_lat = $urandom_range(0, mem_max);
    end else if (s_req) begin
      mem_cnt++;
    end
    check("if_id_valid", 32'(IF_ID_valid), 32'(m_valid));
    check("if_id_pc_plus4", IF_ID_pc_plus4, m_pc4);
    check("if_id_instr", IF_ID_instr, m_instr);
    @(negedge clk);
  endtask

  initial begin
    bit reached;
    mem_max = 0;
    model_reset();
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) step();

    mem_max = 3;
    for (int i = 0; i < 1500; i++) step();

    reached = 0;
    for (int i = 0; i < 400 && !reached; i++) begin
      step();
      if (dead && imem_req) reached = 1;
    end
    check("reach_drop", 32'(reached), 32'h1);

    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the 5-stage MIPS pipeline: owns the PC, issues one instruction-memory request at a time, and loads the IF/ID pipeline register. Sits directly upstream of the hazard detection unit. It obeys that unit's `PC_Write` / `IF_ID_write` stall outputs and the ID-stage branch redirect. A skid buffer holds a returned instruction that arrives while the pipeline is stalled, so no fetch is lost or repeated.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  pipeline clock, all state on rising edge
- `rst_n`  in  1  reset: asynchronous assert, active-low
- `PC_Write`  in  1  0 = hold PC (from hazard detection)
- `IF_ID_write`  in  1  0 = hold IF/ID register (from hazard detection)
- `branch_taken`  in  1  ID-stage redirect, one-cycle pulse
- `branch_target`  in  32  redirect address, word aligned
- `imem_req`  out  1  fetch request; address held stable until `imem_rvalid`
- `imem_addr`  out  32  fetch address
- `imem_rvalid`  in  1  read data valid; may assert in the same cycle as `imem_req` (zero-wait memory)
- `imem_rdata`  in  32  instruction word
- `IF_ID_pc_plus4`  out  32  registered PC+4 of the instruction in IF/ID
- `IF_ID_instr`  out  32  registered instruction
- `IF_ID_valid`  out  1  0 = IF/ID holds a bubble

## Operation
- `stall` = !PC_Write || !IF_ID_write. Only both-high counts as advance.
- `branch_taken` has priority over stall and over any returning data.
- **States: BOOT, FETCH, HOLD, DROP.**
- **BOOT** (reset state)
  - `imem_req`=0.
  - Next cycle goes to FETCH.
- **FETCH**
  - `imem_req`=1, `imem_addr`=PC.
  - `branch_taken`, with or without `imem_rvalid`:
    - PC<=`branch_target`.
    - IF/ID<=bubble.
    - If `imem_rvalid`=0: `drop_addr`<=PC, go DROP. Otherwise stay in FETCH.
  - `imem_rvalid` && !stall:
    - IF/ID<={PC+4, `imem_rdata`, 1}.
    - PC<=PC+4.
    - Stay in FETCH.
  - `imem_rvalid` && stall:
    - `skid`<=`imem_rdata`, go HOLD.
    - PC unchanged.
    - If IF_ID_write=1, IF/ID<=bubble; else IF/ID holds.
  - No `imem_rvalid`:
    - IF/ID<=bubble if IF_ID_write=1, else holds.
- **HOLD**
  - `imem_req`=0.
  - `branch_taken`: discard `skid`, PC<=target, IF/ID<=bubble, go FETCH.
  - !stall: IF/ID<={PC+4, `skid`, 1}, PC<=PC+4, go FETCH.
  - Otherwise: stay. IF/ID bubble-or-hold as above.
- **DROP**
  - `imem_req`=1, `imem_addr`=`drop_addr`, so the outstanding request stays stable.
  - `imem_rvalid`: discard data, go FETCH.
  - Another `branch_taken`: PC<=new target, stay in DROP.
- **Bubble** = {pc_plus4 0, instr `NOP` 32'h0000_0000, valid 0}.
- **Arithmetic**
  - PC+4 is mod 2^32; 32'hFFFF_FFFC wraps to 0.
  - PC[1:0] is forced to 0 on every load.

## Timing
- **Reset values**
  - State=BOOT, PC=`RESET_PC`, `drop_addr`=0, `skid`=0.
  - `IF_ID_pc_plus4`=0, `IF_ID_instr`=0, `IF_ID_valid`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
- **First request:** `imem_req` rises 1 cycle after `rst_n` deasserts.
- **Throughput and latency**
  - Zero-wait memory: 1 instruction per cycle.
  - IF/ID updates on the edge at which `imem_rvalid` is sampled high (1-cycle latency).
- **N-cycle memory:** `imem_addr` is constant for all N cycles; 0 to N-1 bubbles enter IF/ID.
- **Stall recovery:** an instruction buffered in HOLD reaches IF/ID on the first non-stalled edge. The memory is not re-requested.
- **Reset mid-request:** the outstanding response is not tracked. Memory is reset by the same `rst_n`.

## Structure
- Package `pipeline_pkg`:
  - `NOP` = 32'h0000_0000
  - `fetch_state_t` enum {BOOT, FETCH, HOLD, DROP}
  - `WORD_W` = 32
- Sub-module `if_id_pipe_reg`:
  - Inputs: `load`, `flush`, data in.
  - Registered {pc_plus4, instr, valid}.
  - `flush` overrides `load`.
  - Async active-low reset.
- The top level contains the PC register, FSM, skid and `drop_addr` registers, and output muxing.

## Test plan
- **Reset, zero-wait memory returning addr+32'h100**
  - `imem_addr` sequence is 0, 4, 8.
  - IF_ID_instr is 32'h100, 32'h104, ... with valid=1 from the 2nd post-reset edge.
- **3-cycle memory**
  - `imem_addr` holds 0 for 3 cycles.
  - 2 bubbles (valid=0), then instr at PC 0 with pc_plus4=4.
- **Load-use stall: PC_Write=IF_ID_write=0 for 2 cycles while rvalid arrives for PC 8**
  - IF/ID holds its prior value.
  - State HOLD, `imem_req`=0.
  - On release, instr@8 loads with pc_plus4=12. No duplicate fetch of 8.
- **branch_taken with target 32'h40 while a 3-cycle fetch of PC 12 is pending**
  - IF/ID bubble.
  - DROP keeps `imem_addr`=12 until rvalid; that data is discarded.
  - Next request is 32'h40.
- **branch_taken and stall in the same cycle, in HOLD**
  - Redirect wins: `skid` discarded, PC=target, IF_ID_valid=0.
- **PC at 32'hFFFF_FFFC, advance**
  - PC wraps to 0.
  - IF_ID_pc_plus4=0.
- **rst_n pulsed low mid-DROP**
  - All outputs return to reset values immediately, asynchronously.
